stream_demux_1x3: RTL and testbench

STREAM_DEMUX_1X3 -- requirements
Module: stream_demux_1x3

---
 rtl/demux_pkg.sv | 36 +++
 rtl/demux_slot.sv | 64 ++++++
 rtl/stream_demux_1x3.sv | 91 +++++++++
 tb/tb_stream_demux_1x3.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_pkg                                                        |
// | Shared encodings, widths and slot state for the 1x3 demux.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package demux_pkg;

    localparam logic [1:0] SEL_00 = 2'b00;
    localparam logic [1:0] SEL_01 = 2'b01;
    localparam logic [1:0] SEL_10 = 2'b10;

    localparam int DEF_DATA_WIDTH = 11;
    localparam int CNT_WIDTH      = 16;
    localparam int NUM_DEST       = 3;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Bit 1 of the select dominates, so 2'b11 folds onto destination 10.
    function automatic logic [NUM_DEST-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_DEST-1:0] w_onehot;
        w_onehot = '0;
        case (sel)
            SEL_00:  w_onehot[0] = 1'b1;
            SEL_01:  w_onehot[1] = 1'b1;
            SEL_10:  w_onehot[2] = 1'b1;
            default: w_onehot[2] = 1'b1;
        endcase
        return w_onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_slot                                                       |
// | Single-entry valid/ready register, EMPTY/FULL, drain+refill.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready
);

    slot_state_t           r_state;
    slot_state_t           w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // The parent only raises i_wr_en while o_wr_ready is high.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        case (r_state)
            EMPTY: begin
                if (i_wr_en) begin
                    w_state_nxt = FULL;
                    w_data_nxt  = i_wr_data;
                end
            end
            FULL: begin
                if (i_wr_en) begin
                    w_data_nxt = i_wr_data;
                end else if (i_rd_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    assign o_wr_ready = (r_state == EMPTY) || i_rd_ready;
    assign o_rd_valid = (r_state == FULL);
    assign o_rd_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/stream_demux_1x3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_demux_1x3                                                 |
// | Routes one input stream to three buffered destinations.          |
// | Optional per-slot accept counters: STREAM_DEMUX_COUNT_EN.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module stream_demux_1x3
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            select_1x3,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_00,
    output logic [DATA_WIDTH-1:0] out_01,
    output logic [DATA_WIDTH-1:0] out_10,
    output logic                  out_00_valid,
    output logic                  out_01_valid,
    output logic                  out_10_valid,
    input  logic                  out_00_ready,
    input  logic                  out_01_ready,
    input  logic                  out_10_ready
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  cnt_00,
    output logic [CNT_WIDTH-1:0]  cnt_01,
    output logic [CNT_WIDTH-1:0]  cnt_10
`endif
);

    logic [NUM_DEST-1:0]   w_sel;
    logic [NUM_DEST-1:0]   w_slot_ready;
    logic [NUM_DEST-1:0]   w_wr_en;
    logic [NUM_DEST-1:0]   w_out_valid;
    logic [NUM_DEST-1:0]   w_out_ready;
    logic [DATA_WIDTH-1:0] w_out_data [NUM_DEST];

    assign w_sel       = sel_onehot(select_1x3);
    assign w_out_ready = {out_10_ready, out_01_ready, out_00_ready};

    // in_ready must not look at in_valid, so it is formed before the valid gate.
    assign in_ready = |(w_sel & w_slot_ready);
    assign w_wr_en  = w_sel & w_slot_ready & {NUM_DEST{in_valid}};

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_slot
        demux_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_en    (w_wr_en[g]),
            .i_wr_data  (in_data),
            .o_wr_ready (w_slot_ready[g]),
            .o_rd_data  (w_out_data[g]),
            .o_rd_valid (w_out_valid[g]),
            .i_rd_ready (w_out_ready[g])
        );
    end

    assign out_00       = w_out_data[0];
    assign out_01       = w_out_data[1];
    assign out_10       = w_out_data[2];
    assign out_00_valid = w_out_valid[0];
    assign out_01_valid = w_out_valid[1];
    assign out_10_valid = w_out_valid[2];

`ifdef STREAM_DEMUX_COUNT_EN
    for (genvar g = 0; g < NUM_DEST; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_wr_en[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign cnt_00 = g_cnt[0].r_cnt;
    assign cnt_01 = g_cnt[1].r_cnt;
    assign cnt_10 = g_cnt[2].r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1x3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stream_demux_1x3                                              |
// | Self-checking bench: vector table, corner sequences, random run. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_stream_demux_1x3;

    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [1:0]    select_1x3;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_00, out_01, out_10;
    logic          out_00_valid, out_01_valid, out_10_valid;
    logic          out_00_ready, out_01_ready, out_10_ready;
    logic [2:0]    rdy_drv;
`ifdef STREAM_DEMUX_COUNT_EN
    logic [15:0]   cnt_00, cnt_01, cnt_10;
`endif

    always #5 clk = ~clk;

    stream_demux_1x3 #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .select_1x3   (select_1x3),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_00       (out_00),
        .out_01       (out_01),
        .out_10       (out_10),
        .out_00_valid (out_00_valid),
        .out_01_valid (out_01_valid),
        .out_10_valid (out_10_valid),
        .out_00_ready (out_00_ready),
        .out_01_ready (out_01_ready),
        .out_10_ready (out_10_ready)
`ifdef STREAM_DEMUX_COUNT_EN
        ,
        .cnt_00       (cnt_00),
        .cnt_01       (cnt_01),
        .cnt_10       (cnt_10)
`endif
    );

    assign out_00_ready = rdy_drv[0];
    assign out_01_ready = rdy_drv[1];
    assign out_10_ready = rdy_drv[2];

    logic [DW-1:0] o_data [3];
    logic [2:0]    o_valid;
    assign o_data[0] = out_00;
    assign o_data[1] = out_01;
    assign o_data[2] = out_10;
    assign o_valid   = {out_10_valid, out_01_valid, out_00_valid};

    // Reference: each destination is a FIFO that may hold at most one word.
    logic [DW-1:0] mq [3][$];
    int unsigned   m_acc [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [1:0] s);
        return s[1] ? 2 : (s[0] ? 1 : 0);
    endfunction

    function automatic logic model_ready(input logic [1:0] s, input logic [2:0] r);
        int k;
        k = dest_of(s);
        return (mq[k].size() == 0) || r[k];
    endfunction

    task automatic model_clear();
        for (int x = 0; x < 3; x++) begin
            mq[x].delete();
            m_acc[x] = 0;
        end
    endtask

    task automatic model_edge(input logic [DW-1:0] d, input logic [1:0] s,
                              input logic v, input logic [2:0] r);
        int k;
        bit acc;
        k   = dest_of(s);
        acc = v && ((mq[k].size() == 0) || r[k]);
        for (int x = 0; x < 3; x++)
            if (r[x] && mq[x].size() > 0) void'(mq[x].pop_front());
        if (acc) begin
            mq[k].push_back(d);
            if (m_acc[k] < 65535) m_acc[k]++;
        end
    endtask

    task automatic model_check(input string tag);
        for (int x = 0; x < 3; x++) begin
            chk($sformatf("%s_valid%0d", tag, x), 32'(o_valid[x]), 32'(mq[x].size() > 0));
            if (mq[x].size() > 0)
                chk($sformatf("%s_data%0d", tag, x), 32'(o_data[x]), 32'(mq[x][0]));
        end
    endtask

    // Inputs change 1 time unit after a rising edge; in_ready sampled mid-cycle.
    task automatic apply(input logic [DW-1:0] d, input logic [1:0] s, input logic v,
                         input logic [2:0] r, output logic rdy_seen);
        in_data    = d;
        select_1x3 = s;
        in_valid   = v;
        rdy_drv    = r;
        #1 rdy_seen = in_ready;
        @(posedge clk);
        model_edge(d, s, v, r);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        rdy_drv  = 3'b111;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    sel;
        logic          v;
        logic [2:0]    rdy;
        logic          exp_rdy;
        logic [2:0]    exp_val;
        logic [DW-1:0] exp_data;
        int            dest;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    logic          seen;
    logic          exp_r;
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    logic          rv;
    logic [2:0]    rr;

    initial begin
        vt[0]  = '{11'h123, 2'b01, 1'b1, 3'b111, 1'b1, 3'b010, 11'h123, 1};
        vt[1]  = '{11'h7FF, 2'b11, 1'b1, 3'b111, 1'b1, 3'b100, 11'h7FF, 2};
        vt[2]  = '{11'h555, 2'b00, 1'b0, 3'b111, 1'b1, 3'b000, 11'h000, 0};
        vt[3]  = '{11'h0A1, 2'b00, 1'b1, 3'b110, 1'b1, 3'b001, 11'h0A1, 0};
        vt[4]  = '{11'h0A2, 2'b00, 1'b1, 3'b110, 1'b0, 3'b001, 11'h0A1, 0};
        vt[5]  = '{11'h7AA, 2'b00, 1'b0, 3'b110, 1'b0, 3'b001, 11'h0A1, 0};
        vt[6]  = '{11'h0B3, 2'b10, 1'b1, 3'b110, 1'b1, 3'b101, 11'h0B3, 2};
        vt[7]  = '{11'h0A2, 2'b00, 1'b1, 3'b110, 1'b0, 3'b001, 11'h0A1, 0};
        vt[8]  = '{11'h0A2, 2'b00, 1'b1, 3'b111, 1'b1, 3'b001, 11'h0A2, 0};
        vt[9]  = '{11'h000, 2'b00, 1'b0, 3'b111, 1'b1, 3'b000, 11'h000, 0};
        vt[10] = '{11'h3FF, 2'b01, 1'b1, 3'b000, 1'b1, 3'b010, 11'h3FF, 1};
        vt[11] = '{11'h001, 2'b01, 1'b1, 3'b000, 1'b0, 3'b010, 11'h3FF, 1};
        vt[12] = '{11'h001, 2'b10, 1'b1, 3'b000, 1'b1, 3'b110, 11'h001, 2};
        vt[13] = '{11'h000, 2'b01, 1'b0, 3'b110, 1'b1, 3'b000, 11'h000, 0};

        // Reset state, observed while reset is still held.
        rst_n      = 1'b0;
        in_data    = '0;
        select_1x3 = 2'b00;
        in_valid   = 1'b0;
        rdy_drv    = 3'b111;
        model_clear();
        #2;
        chk("rst_valids", 32'(o_valid), 32'd0);
        for (int x = 0; x < 3; x++)
            chk($sformatf("rst_data%0d", x), 32'(o_data[x]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Table of single-cycle vectors with hand-derived expectations.
        for (int i = 0; i < NV; i++) begin
            apply(vt[i].d, vt[i].sel, vt[i].v, vt[i].rdy, seen);
            chk($sformatf("tbl%0d_in_ready", i), 32'(seen), 32'(vt[i].exp_rdy));
            chk($sformatf("tbl%0d_valids", i), 32'(o_valid), 32'(vt[i].exp_val));
            if (vt[i].exp_val[vt[i].dest])
                chk($sformatf("tbl%0d_data", i), 32'(o_data[vt[i].dest]), 32'(vt[i].exp_data));
        end

        // Back-to-back burst into destination 00 with its consumer always ready.
        for (int i = 0; i < 8; i++) begin
            apply(DW'(i), 2'b00, 1'b1, 3'b111, seen);
            chk($sformatf("burst%0d_in_ready", i), 32'(seen), 32'd1);
            chk($sformatf("burst%0d_valid", i), 32'(out_00_valid), 32'd1);
            chk($sformatf("burst%0d_data", i), 32'(out_00), 32'(i));
        end
        apply('0, 2'b00, 1'b0, 3'b111, seen);
        chk("burst_drain", 32'(o_valid), 32'd0);

        // Fill every slot, then assert reset between clock edges.
        apply(11'h111, 2'b00, 1'b1, 3'b000, seen);
        apply(11'h222, 2'b01, 1'b1, 3'b000, seen);
        apply(11'h333, 2'b10, 1'b1, 3'b000, seen);
        model_check("fill");
        chk("fill_valids", 32'(o_valid), 32'd7);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        chk("async_rst_valids", 32'(o_valid), 32'd0);
        for (int x = 0; x < 3; x++)
            chk($sformatf("async_rst_data%0d", x), 32'(o_data[x]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_drv = 3'b111;
        #1 chk("async_rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            apply('0, 2'b00, 1'b0, 3'b111, seen);
            model_check($sformatf("post_rst%0d", i));
            chk($sformatf("post_rst%0d_valids", i), 32'(o_valid), 32'd0);
        end

        // Randomised traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            rd = DW'($urandom);
            rs = 2'($urandom);
            rv = ($urandom_range(0, 9) < 7);
            rr = 3'($urandom_range(0, 7));
            exp_r = model_ready(rs, rr);
            apply(rd, rs, rv, rr, seen);
            chk("rnd_in_ready", 32'(seen), 32'(exp_r));
            model_check("rnd");
        end

`ifdef STREAM_DEMUX_COUNT_EN
        chk("rnd_cnt_00", 32'(cnt_00), m_acc[0]);
        chk("rnd_cnt_01", 32'(cnt_01), m_acc[1]);
        chk("rnd_cnt_10", 32'(cnt_10), m_acc[2]);

        // Saturation: 65537 accepted words into destination 01.
        do_reset();
        in_data    = 11'h055;
        select_1x3 = 2'b01;
        in_valid   = 1'b1;
        rdy_drv    = 3'b111;
        repeat (65537) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("sat_cnt_01", 32'(cnt_01), 32'h0000FFFF);
        chk("sat_cnt_00", 32'(cnt_00), 32'd0);
        chk("sat_cnt_10", 32'(cnt_10), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
